extreme_point_tracker: RTL

Parametrised per-frame object extremity tracker for the camera path. It sits after the binarisation stage and consumes a pixel stream with coordinates. For each frame it finds the topmost, bottommost, leftmost and rightmost foreground pixels and counts the foreground pixels. At each frame boundary it publishes frame-stable extremes, a centre sum, an orientation vector and an object-valid flag.

---
 rtl/extreme_point_tracker_if.sv | 44 ++++
 rtl/extreme_point_tracker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/extreme_point_tracker_if.sv
// Pixel-stream and published-result bundle for extreme_point_tracker.
// master drives pixels and frame markers; slave is the tracker side.
interface extreme_point_tracker_if #(
    parameter int X_W   = 10,
    parameter int Y_W   = 10,
    parameter int CNT_W = 20
) ();
    logic             new_frm;
    logic             pix_valid;
    logic             pix_fg;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;

    logic [X_W-1:0]   top_x;
    logic [Y_W-1:0]   top_y;
    logic [X_W-1:0]   bottom_x;
    logic [Y_W-1:0]   bottom_y;
    logic [X_W-1:0]   left_x;
    logic [Y_W-1:0]   left_y;
    logic [X_W-1:0]   right_x;
    logic [Y_W-1:0]   right_y;
    logic [X_W+1:0]   centre_x;
    logic [Y_W+1:0]   centre_y;
    logic [X_W-1:0]   angle_dx;
    logic [Y_W-1:0]   angle_dy;
    logic             rot_dir;
    logic [CNT_W-1:0] pix_count;
    logic             obj_valid;
    logic             result_valid;

    modport master (
        output new_frm, pix_valid, pix_fg, pix_x, pix_y,
        input  top_x, top_y, bottom_x, bottom_y, left_x, left_y, right_x, right_y,
        input  centre_x, centre_y, angle_dx, angle_dy, rot_dir,
        input  pix_count, obj_valid, result_valid
    );

    modport slave (
        input  new_frm, pix_valid, pix_fg, pix_x, pix_y,
        output top_x, top_y, bottom_x, bottom_y, left_x, left_y, right_x, right_y,
        output centre_x, centre_y, angle_dx, angle_dy, rot_dir,
        output pix_count, obj_valid, result_valid
    );
endinterface

// File: rtl/extreme_point_tracker.sv
// Per-frame extremity tracker: finds top/bottom/left/right foreground pixels and publishes
// them one cycle after a frame-edge snapshot. Macro EPT_ANGLE_EN builds the orientation logic.
module extreme_point_tracker #(
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int CNT_W   = 20,
    parameter int MIN_PIX = 16
) (
    input  logic clk,
    input  logic rst,
    extreme_point_tracker_if.slave bus
);
    localparam logic [X_W-1:0]   XMAX  = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0]   YMAX  = Y_W'(FRAME_H - 1);
    localparam logic [X_W:0]     FW_L  = (X_W + 1)'(FRAME_W);
    localparam logic [Y_W:0]     FH_L  = (Y_W + 1)'(FRAME_H);
    localparam logic [CNT_W:0]   MIN_L = (CNT_W + 1)'(MIN_PIX);

    typedef enum logic [0:0] {IDLE, ACCUM} state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    state_e state_q, state_d;
    logic   r1_q, r2_q, frm_edge, snap, accept;

    logic [X_W-1:0]   top_x_q, top_x_d, bot_x_q, bot_x_d, lft_x_q, lft_x_d, rgt_x_q, rgt_x_d;
    logic [Y_W-1:0]   top_y_q, top_y_d, bot_y_q, bot_y_d, lft_y_q, lft_y_d, rgt_y_q, rgt_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [X_W-1:0]   s_top_x_q, s_bot_x_q, s_lft_x_q, s_rgt_x_q;
    logic [Y_W-1:0]   s_top_y_q, s_bot_y_q, s_lft_y_q, s_rgt_y_q;
    logic [CNT_W-1:0] s_cnt_q;
    logic             snap_vld_q;

    logic [X_W+1:0]   o_cx_q;
    logic [Y_W+1:0]   o_cy_q;
    logic [X_W-1:0]   o_dx_q, o_tx_q, o_bx_q, o_lx_q, o_rx_q;
    logic [Y_W-1:0]   o_dy_q, o_ty_q, o_by_q, o_ly_q, o_ry_q;
    logic             o_rot_q, o_obj_q, o_rv_q;
    logic [CNT_W-1:0] o_cnt_q;

    logic             obj_v;
    logic [X_W+1:0]   cx_sum;
    logic [Y_W+1:0]   cy_sum;
    logic [X_W-1:0]   ang_dx;
    logic [Y_W-1:0]   ang_dy;
    logic             ang_rot;

    assign frm_edge = r1_q & ~r2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q    <= 1'b0;
            r2_q    <= 1'b0;
            state_q <= IDLE;
        end else begin
            r1_q    <= bus.new_frm;
            r2_q    <= r1_q;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap    = 1'b0;
        case (state_q)
            IDLE:    if (frm_edge) state_d = ACCUM;
            ACCUM:   snap = frm_edge;
            default: state_d = IDLE;
        endcase
    end

    assign accept = (state_q == ACCUM) & ~frm_edge & bus.pix_valid & bus.pix_fg &
                    ({1'b0, bus.pix_x} < FW_L) & ({1'b0, bus.pix_y} < FH_L);

    // Working registers: reload on snapshot, otherwise apply tie-broken extreme updates
    always_comb begin
        top_x_d = top_x_q;  top_y_d = top_y_q;
        bot_x_d = bot_x_q;  bot_y_d = bot_y_q;
        lft_x_d = lft_x_q;  lft_y_d = lft_y_q;
        rgt_x_d = rgt_x_q;  rgt_y_d = rgt_y_q;
        cnt_d   = cnt_q;
        if (snap) begin
            top_x_d = XMAX;   top_y_d = YMAX;
            bot_x_d = '0;     bot_y_d = '0;
            lft_x_d = XMAX;   lft_y_d = '0;
            rgt_x_d = '0;     rgt_y_d = YMAX;
            cnt_d   = '0;
        end else if (accept) begin
            if (bus.pix_y < top_y_q || (bus.pix_y == top_y_q && bus.pix_x < top_x_q)) begin
                top_x_d = bus.pix_x;  top_y_d = bus.pix_y;
            end
            if (bus.pix_y > bot_y_q || (bus.pix_y == bot_y_q && bus.pix_x > bot_x_q)) begin
                bot_x_d = bus.pix_x;  bot_y_d = bus.pix_y;
            end
            if (bus.pix_x < lft_x_q || (bus.pix_x == lft_x_q && bus.pix_y > lft_y_q)) begin
                lft_x_d = bus.pix_x;  lft_y_d = bus.pix_y;
            end
            if (bus.pix_x > rgt_x_q || (bus.pix_x == rgt_x_q && bus.pix_y < rgt_y_q)) begin
                rgt_x_d = bus.pix_x;  rgt_y_d = bus.pix_y;
            end
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_x_q <= XMAX;  top_y_q <= YMAX;
            bot_x_q <= '0;    bot_y_q <= '0;
            lft_x_q <= XMAX;  lft_y_q <= '0;
            rgt_x_q <= '0;    rgt_y_q <= YMAX;
            cnt_q   <= '0;
        end else begin
            top_x_q <= top_x_d;  top_y_q <= top_y_d;
            bot_x_q <= bot_x_d;  bot_y_q <= bot_y_d;
            lft_x_q <= lft_x_d;  lft_y_q <= lft_y_d;
            rgt_x_q <= rgt_x_d;  rgt_y_q <= rgt_y_d;
            cnt_q   <= cnt_d;
        end
    end

    // Snapshot stage
    always_ff @(posedge clk) begin
        if (rst) begin
            s_top_x_q <= XMAX;  s_top_y_q <= YMAX;
            s_bot_x_q <= '0;    s_bot_y_q <= '0;
            s_lft_x_q <= XMAX;  s_lft_y_q <= '0;
            s_rgt_x_q <= '0;    s_rgt_y_q <= YMAX;
            s_cnt_q   <= '0;
            snap_vld_q <= 1'b0;
        end else begin
            snap_vld_q <= snap;
            if (snap) begin
                s_top_x_q <= top_x_q;  s_top_y_q <= top_y_q;
                s_bot_x_q <= bot_x_q;  s_bot_y_q <= bot_y_q;
                s_lft_x_q <= lft_x_q;  s_lft_y_q <= lft_y_q;
                s_rgt_x_q <= rgt_x_q;  s_rgt_y_q <= rgt_y_q;
                s_cnt_q   <= cnt_q;
            end
        end
    end

    assign obj_v  = ({1'b0, s_cnt_q} >= MIN_L);
    assign cx_sum = {2'b00, s_top_x_q} + {2'b00, s_bot_x_q} + {2'b00, s_lft_x_q} + {2'b00, s_rgt_x_q};
    assign cy_sum = {2'b00, s_top_y_q} + {2'b00, s_bot_y_q} + {2'b00, s_lft_y_q} + {2'b00, s_rgt_y_q};

`ifdef EPT_ANGLE_EN
    logic [Y_W-1:0] lt_dy;
    logic [X_W-1:0] lt_dx;
    assign lt_dy   = s_lft_y_q - s_top_y_q;
    assign lt_dx   = s_top_x_q - s_lft_x_q;
    // Widths may differ, so the compare is done on zero-extended 32-bit values
    assign ang_rot = (32'(lt_dy) < 32'(lt_dx));
    assign ang_dx  = ang_rot ? lt_dx : (s_rgt_x_q - s_top_x_q);
    assign ang_dy  = ang_rot ? lt_dy : (s_rgt_y_q - s_top_y_q);
`else
    assign ang_rot = 1'b0;
    assign ang_dx  = '0;
    assign ang_dy  = '0;
`endif

    // Publish stage
    always_ff @(posedge clk) begin
        if (rst) begin
            o_tx_q <= '0;  o_ty_q <= '0;  o_bx_q <= '0;  o_by_q <= '0;
            o_lx_q <= '0;  o_ly_q <= '0;  o_rx_q <= '0;  o_ry_q <= '0;
            o_cx_q <= '0;  o_cy_q <= '0;  o_dx_q <= '0;  o_dy_q <= '0;
            o_rot_q <= 1'b0;  o_cnt_q <= '0;  o_obj_q <= 1'b0;  o_rv_q <= 1'b0;
        end else begin
            o_rv_q <= snap_vld_q;
            if (snap_vld_q) begin
                o_tx_q  <= s_top_x_q;  o_ty_q <= s_top_y_q;
                o_bx_q  <= s_bot_x_q;  o_by_q <= s_bot_y_q;
                o_lx_q  <= s_lft_x_q;  o_ly_q <= s_lft_y_q;
                o_rx_q  <= s_rgt_x_q;  o_ry_q <= s_rgt_y_q;
                o_cnt_q <= s_cnt_q;
                o_obj_q <= obj_v;
                o_cx_q  <= obj_v ? cx_sum  : '0;
                o_cy_q  <= obj_v ? cy_sum  : '0;
                o_dx_q  <= obj_v ? ang_dx  : '0;
                o_dy_q  <= obj_v ? ang_dy  : '0;
                o_rot_q <= obj_v ? ang_rot : 1'b0;
            end
        end
    end

    assign bus.top_x        = o_tx_q;
    assign bus.top_y        = o_ty_q;
    assign bus.bottom_x     = o_bx_q;
    assign bus.bottom_y     = o_by_q;
    assign bus.left_x       = o_lx_q;
    assign bus.left_y       = o_ly_q;
    assign bus.right_x      = o_rx_q;
    assign bus.right_y      = o_ry_q;
    assign bus.centre_x     = o_cx_q;
    assign bus.centre_y     = o_cy_q;
    assign bus.angle_dx     = o_dx_q;
    assign bus.angle_dy     = o_dy_q;
    assign bus.rot_dir      = o_rot_q;
    assign bus.pix_count    = o_cnt_q;
    assign bus.obj_valid    = o_obj_q;
    assign bus.result_valid = o_rv_q;
endmodule
